vip_ram_arbiter: RTL and testbench

- Shares the single VIP RAM access port among NREQ requesters: manager VIP sub-menu, checkout discount lookup, and new-member registration.
- Grants one requester at a time using round-robin arbitration.
- Sequences each access as issue, then wait for the RAM latency, then acknowledge.
- Rejects malformed discount writes before they reach the RAM.
- Sits between the manager/user FSMs and the VIP RAM, and replaces their direct r_wr_ram_vip_o / r_vip_off_o drives.

---
 rtl/vip_ram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_vip_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_ram_arbiter.sv
// -----------------------------------------------------------------------------
// vip_ram_arbiter
//   Shares the single VIP RAM access port among NREQ requesters (manager VIP
//   sub-menu, checkout discount lookup, new-member registration). One
//   requester is granted at a time in round-robin order. Each access is run
//   as IDLE -> ISSUE -> WAIT -> DONE. A discount "set" with an illegal code
//   skips the RAM and completes straight away with err.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         block enable; low aborts the transaction in flight and holds IDLE
//   req        per-requester request level, held until ack
//   op_flat    2 bits per requester: 00 none, 01 revoke, 10 read, 11 set
//   off_flat   5 bits per requester: discount code, used only by set
//   gnt        one-hot grant, held for the whole transaction
//   busy       high whenever the FSM is not in IDLE
//   ack        1-cycle completion pulse to the granted requester
//   err        1-cycle pulse together with ack for a rejected set
//   rd_off_o   discount captured by the last read
//   ram_wr_o   RAM command (op encoding), non-zero only in the ISSUE cycle
//   ram_off_o  discount code driven to the RAM
//   ram_off_i  RAM read data
// -----------------------------------------------------------------------------
module vip_ram_arbiter #(
  parameter int NREQ    = 3,
  parameter int RAM_LAT = 2,
  parameter int OFF_MAX = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op_flat,
  input  logic [5*NREQ-1:0] off_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [4:0]        rd_off_o,
  output logic [1:0]        ram_wr_o,
  output logic [4:0]        ram_off_o,
  input  logic [4:0]        ram_off_i
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A set operation must carry a non-zero code no larger than OFF_MAX.
  function automatic logic off_legal(input logic [4:0] off);
    return (off != 5'd0) && (off <= 5'(OFF_MAX));
  endfunction

  state_t            state_r, state_n;
  logic [PW-1:0]     ptr_r, ptr_n;
  logic [PW-1:0]     sel_r, sel_n;
  logic [1:0]        op_r, op_n;
  logic [4:0]        off_r, off_n;
  logic [CW-1:0]     cnt_r, cnt_n;
  logic [NREQ-1:0]   gnt_r, gnt_n;
  logic              busy_r, busy_n;
  logic              ack_r, ack_n;
  logic              err_r, err_n;
  logic [4:0]        rd_off_r, rd_off_n;
  logic [1:0]        ram_wr_r, ram_wr_n;
  logic [4:0]        ram_off_r, ram_off_n;

  logic [NREQ-1:0]   elig_s;
  logic              found_s;
  logic [PW-1:0]     pick_s;
  logic [PW-1:0]     cand_s;
  logic [1:0]        pick_op_s;
  logic [4:0]        pick_off_s;
  logic [PW-1:0]     ptr_next_s;

  // Eligibility: requesting and asking for a real operation.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = req[i] & (op_flat[2*i +: 2] != 2'b00);
    end
  end

  // Round-robin pick: first eligible requester scanning ptr, ptr+1, ...
  always_comb begin
    found_s    = 1'b0;
    pick_s     = ptr_r;
    cand_s     = '0;
    pick_op_s  = 2'b00;
    pick_off_s = 5'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s  = PW'((int'(ptr_r) + k) % NREQ);
      pick_s  = (!found_s && elig_s[cand_s]) ? cand_s : pick_s;
      found_s = found_s | elig_s[cand_s];
    end
    for (int i = 0; i < NREQ; i++) begin
      pick_op_s  = (pick_s == PW'(i)) ? op_flat[2*i +: 2]  : pick_op_s;
      pick_off_s = (pick_s == PW'(i)) ? off_flat[5*i +: 5] : pick_off_s;
    end
  end

  // The requester served last drops to the lowest priority.
  assign ptr_next_s = (sel_r == PW'(NREQ-1)) ? {PW{1'b0}} : (sel_r + PW'(1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n   = state_r;
    ptr_n     = ptr_r;
    sel_n     = sel_r;
    op_n      = op_r;
    off_n     = off_r;
    cnt_n     = cnt_r;
    gnt_n     = gnt_r;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    rd_off_n  = rd_off_r;
    ram_wr_n  = 2'b00;
    ram_off_n = ram_off_r;

    if (!en) begin
      // Abort: no ack for the dropped transaction, pointer and read data kept.
      state_n = ST_IDLE;
      gnt_n   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            sel_n = pick_s;
            op_n  = pick_op_s;
            off_n = pick_off_s;
            gnt_n = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
            if ((pick_op_s == 2'b11) && !off_legal(pick_off_s)) begin
              // Rejected set never reaches the RAM.
              state_n = ST_DONE;
              ack_n   = 1'b1;
              err_n   = 1'b1;
            end else begin
              state_n   = ST_ISSUE;
              ram_wr_n  = pick_op_s;
              ram_off_n = (pick_op_s == 2'b11) ? pick_off_s : 5'd0;
            end
          end else begin
            gnt_n = '0;
          end
        end
        ST_ISSUE: begin
          state_n = ST_WAIT;
          cnt_n   = CW'(RAM_LAT - 1);
        end
        ST_WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_n = ST_DONE;
            ack_n   = 1'b1;
            // Read data becomes valid RAM_LAT cycles after the ISSUE cycle.
            rd_off_n = (op_r == 2'b10) ? ram_off_i : rd_off_r;
          end else begin
            cnt_n = cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          ptr_n   = ptr_next_s;
        end
        default: begin
          state_n = ST_IDLE;
          gnt_n   = '0;
        end
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      sel_r     <= '0;
      op_r      <= 2'b00;
      off_r     <= 5'd0;
      cnt_r     <= '0;
      gnt_r     <= '0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      rd_off_r  <= 5'd0;
      ram_wr_r  <= 2'b00;
      ram_off_r <= 5'd0;
    end else begin
      state_r   <= state_n;
      ptr_r     <= ptr_n;
      sel_r     <= sel_n;
      op_r      <= op_n;
      off_r     <= off_n;
      cnt_r     <= cnt_n;
      gnt_r     <= gnt_n;
      busy_r    <= busy_n;
      ack_r     <= ack_n;
      err_r     <= err_n;
      rd_off_r  <= rd_off_n;
      ram_wr_r  <= ram_wr_n;
      ram_off_r <= ram_off_n;
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign ack       = ack_r;
  assign err       = err_r;
  assign rd_off_o  = rd_off_r;
  assign ram_wr_o  = ram_wr_r;
  assign ram_off_o = ram_off_r;

endmodule

// File: tb/tb_vip_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vip_ram_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (grant time + age of the current transaction) predicts
//   every output each cycle.
// -----------------------------------------------------------------------------
module tb_vip_ram_arbiter;

  localparam int NREQ    = 3;
  localparam int RAM_LAT = 2;
  localparam int OFF_MAX = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op_flat;
  logic [5*NREQ-1:0] off_flat;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              ack;
  logic              err;
  logic [4:0]        rd_off_o;
  logic [1:0]        ram_wr_o;
  logic [4:0]        ram_off_o;
  logic [4:0]        ram_off_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one transaction at a time, tracked by its age.
  bit         m_active;
  int         m_idx;
  int         m_age;
  int         m_ptr;
  bit         m_bad;
  logic [1:0] m_op;
  logic [4:0] m_off;
  logic [4:0] m_rd_off;
  logic [4:0] m_ram_off;

  vip_ram_arbiter #(.NREQ(NREQ), .RAM_LAT(RAM_LAT), .OFF_MAX(OFF_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .op_flat   (op_flat),
    .off_flat  (off_flat),
    .gnt       (gnt),
    .busy      (busy),
    .ack       (ack),
    .err       (err),
    .rd_off_o  (rd_off_o),
    .ram_wr_o  (ram_wr_o),
    .ram_off_o (ram_off_o),
    .ram_off_i (ram_off_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Age (cycles after the grant edge) at which ack appears.
  function automatic int done_age();
    return m_bad ? 1 : RAM_LAT + 2;
  endfunction

  function automatic bit model_ack();
    return m_active && (m_age == done_age());
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    bit found;
    int idx;
    if (rst) begin
      m_active  = 1'b0;
      m_ptr     = 0;
      m_age     = 0;
      m_rd_off  = 5'd0;
      m_ram_off = 5'd0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_age == done_age()) begin
        m_active = 1'b0;
        m_ptr    = (m_idx + 1) % NREQ;
      end else begin
        m_age++;
        if (m_age == done_age() && m_op == 2'b10) m_rd_off = ram_off_i;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req[idx] && op_flat[2*idx +: 2] != 2'b00) begin
          found = 1'b1;
          m_idx = idx;
        end
      end
      if (found) begin
        m_active = 1'b1;
        m_age    = 1;
        m_op     = op_flat[2*m_idx +: 2];
        m_off    = off_flat[5*m_idx +: 5];
        m_bad    = (m_op == 2'b11) && (m_off == 5'd0 || m_off > 5'(OFF_MAX));
        if (!m_bad) m_ram_off = (m_op == 2'b11) ? m_off : 5'd0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] e_gnt;
    logic [1:0]      e_wr;
    e_gnt = m_active ? (NREQ'(1) << m_idx) : '0;
    e_wr  = (m_active && !m_bad && m_age == 1) ? m_op : 2'b00;
    check_eq("gnt",       32'(gnt),       32'(e_gnt));
    check_eq("busy",      32'(busy),      32'(m_active));
    check_eq("ack",       32'(ack),       32'(model_ack()));
    check_eq("err",       32'(err),       32'(model_ack() && m_bad));
    check_eq("ram_wr_o",  32'(ram_wr_o),  32'(e_wr));
    check_eq("ram_off_o", 32'(ram_off_o), 32'(m_ram_off));
    check_eq("rd_off_o",  32'(rd_off_o),  32'(m_rd_off));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic r, input logic [1:0] op, input logic [4:0] off);
    req[i]            = r;
    op_flat[2*i +: 2] = op;
    off_flat[5*i +: 5] = off;
  endtask

  initial begin
    int ack_t[4];
    logic [NREQ-1:0] ack_g[4];
    int n_ack;

    rst = 1'b1; en = 1'b1; req = '0; op_flat = '0; off_flat = '0; ram_off_i = 5'd0;
    m_active = 1'b0; m_idx = 0; m_age = 0; m_ptr = 0; m_bad = 1'b0;
    m_op = 2'b00; m_off = 5'd0; m_rd_off = 5'd0; m_ram_off = 5'd0;

    // Reset then idle.
    cycle(); cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_wr",   32'(ram_wr_o), 32'd0);

    // Single legal set from requester 0.
    set_req(0, 1'b1, 2'b11, 5'd5);
    cycle();
    check_eq("set_gnt", 32'(gnt), 32'b001);
    check_eq("set_wr",  32'(ram_wr_o), 32'b11);
    check_eq("set_off", 32'(ram_off_o), 32'd5);
    cycle();
    check_eq("set_wr_once", 32'(ram_wr_o), 32'b00);
    cycle();
    check_eq("set_no_ack_yet", 32'(ack), 32'd0);
    cycle();
    check_eq("set_ack", 32'(ack), 32'd1);
    check_eq("set_err", 32'(err), 32'd0);
    set_req(0, 1'b0, 2'b00, 5'd0);
    cycle();
    check_eq("set_busy_drop", 32'(busy), 32'd0);

    // Read from requester 1, RAM returns 7.
    ram_off_i = 5'd7;
    set_req(1, 1'b1, 2'b10, 5'd0);
    cycle();
    check_eq("rd_gnt", 32'(gnt), 32'b010);
    check_eq("rd_wr",  32'(ram_wr_o), 32'b10);
    cycle(); cycle(); cycle();
    check_eq("rd_ack", 32'(ack), 32'd1);
    check_eq("rd_data", 32'(rd_off_o), 32'd7);
    set_req(1, 1'b0, 2'b00, 5'd0);
    ram_off_i = 5'd3;
    cycle(); cycle();
    check_eq("rd_hold", 32'(rd_off_o), 32'd7);

    // Illegal sets from requester 2: code 0, then code 12.
    set_req(2, 1'b1, 2'b11, 5'd0);
    cycle();
    check_eq("bad0_ack", 32'(ack), 32'd1);
    check_eq("bad0_err", 32'(err), 32'd1);
    check_eq("bad0_gnt", 32'(gnt), 32'b100);
    check_eq("bad0_wr",  32'(ram_wr_o), 32'b00);
    set_req(2, 1'b0, 2'b00, 5'd0);
    cycle();
    set_req(2, 1'b1, 2'b11, 5'd12);
    cycle();
    check_eq("bad12_err", 32'(err), 32'd1);
    check_eq("bad12_wr",  32'(ram_wr_o), 32'b00);
    set_req(2, 1'b0, 2'b00, 5'd0);
    cycle(); cycle();

    // Round-robin with all three requesting continuously.
    set_req(0, 1'b1, 2'b10, 5'd0);
    set_req(1, 1'b1, 2'b11, 5'd3);
    set_req(2, 1'b1, 2'b01, 5'd0);
    n_ack = 0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (ack && n_ack < 4) begin
        ack_t[n_ack] = c;
        ack_g[n_ack] = gnt;
        n_ack++;
      end
    end
    check_eq("rr_count", 32'(n_ack), 32'd4);
    if (n_ack == 4) begin
      check_eq("rr_g0", 32'(ack_g[0]), 32'b001);
      check_eq("rr_g1", 32'(ack_g[1]), 32'b010);
      check_eq("rr_g2", 32'(ack_g[2]), 32'b100);
      check_eq("rr_g3", 32'(ack_g[3]), 32'b001);
      for (int j = 1; j < 4; j++) check_eq("rr_spacing", 32'(ack_t[j] - ack_t[j-1]), 32'(RAM_LAT + 3));
    end
    req = '0;
    for (int c = 0; c < 8; c++) cycle();

    // en low during WAIT, with a competing request pending.
    set_req(1, 1'b1, 2'b10, 5'd0);
    cycle();
    check_eq("en_gnt", 32'(gnt), 32'b010);
    cycle();
    set_req(0, 1'b1, 2'b01, 5'd0);
    en = 1'b0;
    cycle();
    check_eq("en_abort_gnt",  32'(gnt), 32'd0);
    check_eq("en_abort_busy", 32'(busy), 32'd0);
    cycle();
    check_eq("en_abort_ack", 32'(ack), 32'd0);
    en = 1'b1;
    for (int c = 0; c < 12; c++) cycle();
    req = '0;
    for (int c = 0; c < 8; c++) cycle();

    // rst during WAIT takes effect immediately.
    set_req(2, 1'b1, 2'b10, 5'd0);
    cycle(); cycle();
    rst = 1'b1;
    #1;
    check_eq("rst_gnt",  32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack",  32'(ack), 32'd0);
    check_eq("rst_rd",   32'(rd_off_o), 32'd0);
    cycle();
    rst = 1'b0;
    set_req(2, 1'b0, 2'b00, 5'd0);
    for (int c = 0; c < 3; c++) cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(299) == 0);
      en  = ($urandom_range(24) != 0);
      ram_off_i = 5'($urandom_range(31));
      for (int i = 0; i < NREQ; i++) begin
        if (m_active && m_idx == i) begin
          if (model_ack() || $urandom_range(9) == 0) req[i] = 1'b0;
          if ($urandom_range(3) == 0) begin
            op_flat[2*i +: 2]  = 2'($urandom_range(3));
            off_flat[5*i +: 5] = 5'($urandom_range(15));
          end
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) set_req(i, 1'b1, 2'($urandom_range(3)), 5'($urandom_range(15)));
        end else if ($urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
